// File: rtl/bus_mem_responder.sv
// Line-wide memory responder for the shared cache line bus: one outstanding request,
// programmable read/write latency, four-phase valid handshake, out-of-range error.
module bus_mem_responder #(
    parameter int unsigned BUS_ADDRESS_WIDTH    = 20,
    parameter int unsigned BUS_DATA_WIDTH_SHIFT = 4,
    parameter int unsigned MEM_LINES            = 4096,
    parameter int unsigned MEM_BASE_LINE        = 0,
    parameter int unsigned READ_LATENCY         = 8,
    parameter int unsigned WRITE_LATENCY        = 4
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] bus_addr_i,
    input  logic                                            bus_we_i,
    input  logic [(8<<BUS_DATA_WIDTH_SHIFT)-1:0]            bus_wdata_i,
    input  logic                                            bus_valid_i,
    output logic                                            bus_valid_o,
    output logic [(8<<BUS_DATA_WIDTH_SHIFT)-1:0]            bus_rdata_o,
    output logic                                            bus_err_o,
    output logic                                            busy_o
);

    localparam int unsigned LINE_AW = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;
    localparam int unsigned DW      = 8 << BUS_DATA_WIDTH_SHIFT;
    localparam int unsigned IDX_W   = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               we_q;
    logic               oor_q;
    logic [DW-1:0]      wdata_q;
    logic               valid_q;
    logic               err_q;
    logic [DW-1:0]      rdata_q;

    logic [DW-1:0]      mem_q [MEM_LINES];

    // Range check and storage index of the line presented on the bus
    logic [32:0]        line_ext_c;
    logic               oor_c;
    logic [IDX_W-1:0]   idx_c;
    logic               mem_we_c;

    assign line_ext_c = 33'(bus_addr_i);
    assign oor_c      = (line_ext_c < 33'(MEM_BASE_LINE)) ||
                        (line_ext_c >= (33'(MEM_BASE_LINE) + 33'(MEM_LINES)));
    assign idx_c      = IDX_W'(bus_addr_i - LINE_AW'(MEM_BASE_LINE));

    // A write lands only on the completing edge, and only if the request is still held
    assign mem_we_c = (state_q == ST_WAIT) && (cnt_q == '0) && bus_valid_i && we_q && !oor_q;

    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus_valid_i) begin
                        idx_q   <= idx_c;
                        we_q    <= bus_we_i;
                        oor_q   <= oor_c;
                        wdata_q <= bus_wdata_i;
                        cnt_q   <= bus_we_i ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!bus_valid_i) begin
                        // Initiator withdrew: drop the transaction silently
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        valid_q <= 1'b1;
                        err_q   <= oor_q;
                        rdata_q <= (!we_q && !oor_q) ? mem_q[idx_q] : '0;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (!bus_valid_i) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_valid_o = valid_q;
    assign bus_err_o   = err_q;
    assign bus_rdata_o = rdata_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: a vector table of line transactions on two
// instances (base 0 / base 0x100 with short latencies) plus hold, abort and reset sequences.
module tb_bus_mem_responder;

    localparam logic [127:0] DEADV = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_0001;
    localparam logic [127:0] A5V   = {16{8'hA5}};
    localparam logic [127:0] V5AV  = {16{8'h5A}};
    localparam logic [127:0] C3V   = 128'hC3C3_0000_1111_2222_3333_4444_5555_C3C3;
    localparam logic [127:0] V1V   = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
    localparam logic [127:0] V2V   = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    localparam logic [127:0] V3V   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [127:0] ABV   = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  addr = '0;
    logic         we = 1'b0;
    logic [127:0] wdata = '0;
    logic         valid0 = 1'b0;
    logic         valid1 = 1'b0;
    logic         v0, e0, b0, v1, e1, b1;
    logic [127:0] rd0, rd1;

    always #5 clk = ~clk;

    bus_mem_responder u_dut0 (
        .clk_i(clk), .rst_i(rst), .bus_addr_i(addr), .bus_we_i(we), .bus_wdata_i(wdata),
        .bus_valid_i(valid0), .bus_valid_o(v0), .bus_rdata_o(rd0), .bus_err_o(e0), .busy_o(b0)
    );

    bus_mem_responder #(
        .MEM_BASE_LINE(32'h100), .READ_LATENCY(3), .WRITE_LATENCY(1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .bus_addr_i(addr), .bus_we_i(we), .bus_wdata_i(wdata),
        .bus_valid_i(valid1), .bus_valid_o(v1), .bus_rdata_o(rd1), .bus_err_o(e1), .busy_o(b1)
    );

    typedef struct {
        bit           sel;
        bit           we;
        logic [15:0]  line;
        logic [127:0] wd;
        int           lat;
        bit           err;
        logic [127:0] rd;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic o_valid(input bit s);
        return s ? v1 : v0;
    endfunction
    function automatic logic o_err(input bit s);
        return s ? e1 : e0;
    endfunction
    function automatic logic o_busy(input bit s);
        return s ? b1 : b0;
    endfunction
    function automatic logic [127:0] o_rdata(input bit s);
        return s ? rd1 : rd0;
    endfunction

    task automatic set_valid(input bit s, input logic v);
        if (s) valid1 = v;
        else   valid0 = v;
    endtask

    task automatic start_req(input bit s, input bit w, input logic [15:0] line, input logic [127:0] wd);
        addr  = line;
        we    = w;
        wdata = wd;
        set_valid(s, 1'b1);
    endtask

    // Counts edges after the accept edge until valid rises (bounded)
    task automatic wait_valid(input bit s, input int lat, input string name);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!o_valid(s) && k < 64);
        chk({name, " latency"}, 128'(k), 128'(lat));
    endtask

    task automatic wait_resp(input bit s, input int lat, input string name);
        @(posedge clk); #1;
        chk({name, " busy after accept"}, 128'(o_busy(s)), 128'(1));
        chk({name, " valid low after accept"}, 128'(o_valid(s)), 128'(0));
        wait_valid(s, lat, name);
    endtask

    task automatic end_req(input bit s, input string name);
        set_valid(s, 1'b0);
        @(posedge clk); #1;
        chk({name, " valid drop"}, 128'(o_valid(s)), 128'(0));
        chk({name, " err drop"}, 128'(o_err(s)), 128'(0));
        chk({name, " idle"}, 128'(o_busy(s)), 128'(0));
    endtask

    task automatic do_txn(input bit s, input bit w, input logic [15:0] line, input logic [127:0] wd,
                          input int lat, input bit err, input logic [127:0] rd, input string name);
        start_req(s, w, line, wd);
        wait_resp(s, lat, name);
        chk({name, " err"}, 128'(o_err(s)), 128'(err));
        chk({name, " rdata"}, o_rdata(s), rd);
        end_req(s, name);
        chk({name, " rdata kept"}, o_rdata(s), rd);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 16'h0012, DEADV, 4, 1'b0, '0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0012, '0,    8, 1'b0, DEADV};
        tbl[2]  = '{1'b0, 1'b1, 16'h0000, A5V,   4, 1'b0, '0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0FFF, V5AV,  4, 1'b0, '0};
        tbl[4]  = '{1'b0, 1'b0, 16'h0FFF, '0,    8, 1'b0, V5AV};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, '0,    8, 1'b0, A5V};
        tbl[6]  = '{1'b0, 1'b0, 16'h1000, '0,    8, 1'b1, '0};
        tbl[7]  = '{1'b0, 1'b1, 16'h1000, V2V,   4, 1'b1, '0};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, '0,    8, 1'b0, A5V};
        tbl[9]  = '{1'b0, 1'b1, 16'h0345, C3V,   4, 1'b0, '0};
        tbl[10] = '{1'b0, 1'b0, 16'h0345, '0,    8, 1'b0, C3V};
        tbl[11] = '{1'b0, 1'b0, 16'h0012, '0,    8, 1'b0, DEADV};
        tbl[12] = '{1'b1, 1'b1, 16'h0100, V1V,   1, 1'b0, '0};
        tbl[13] = '{1'b1, 1'b0, 16'h0100, '0,    3, 1'b0, V1V};
        tbl[14] = '{1'b1, 1'b0, 16'h00FF, '0,    3, 1'b1, '0};
        tbl[15] = '{1'b1, 1'b0, 16'h1100, '0,    3, 1'b1, '0};
        tbl[16] = '{1'b1, 1'b1, 16'h00FF, V2V,   1, 1'b1, '0};
        tbl[17] = '{1'b1, 1'b1, 16'h1100, V2V,   1, 1'b1, '0};
        tbl[18] = '{1'b1, 1'b1, 16'h10FF, V3V,   1, 1'b0, '0};
        tbl[19] = '{1'b1, 1'b0, 16'h10FF, '0,    3, 1'b0, V3V};
        tbl[20] = '{1'b1, 1'b0, 16'h0100, '0,    3, 1'b0, V1V};

        #12;
        chk("reset valid0", 128'(v0), 128'(0));
        chk("reset busy0", 128'(b0), 128'(0));
        chk("reset err0", 128'(e0), 128'(0));
        chk("reset rdata0", rd0, '0);
        chk("reset valid1", 128'(v1), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            do_txn(tbl[i].sel, tbl[i].we, tbl[i].line, tbl[i].wd, tbl[i].lat, tbl[i].err,
                   tbl[i].rd, $sformatf("vec%0d", i));
        end

        // Hold: inputs changed during WAIT/RESP are ignored, response held 5 cycles
        start_req(1'b0, 1'b0, 16'h0012, '0);
        @(posedge clk); #1;
        addr  = 16'h0000;
        we    = 1'b1;
        wdata = '1;
        wait_valid(1'b0, 8, "hold");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hold valid c%0d", i), 128'(v0), 128'(1));
            chk($sformatf("hold rdata c%0d", i), rd0, DEADV);
        end
        valid0 = 1'b0;
        we     = 1'b0;
        @(posedge clk); #1;
        chk("hold valid drop", 128'(v0), 128'(0));
        start_req(1'b0, 1'b0, 16'h0000, '0);
        @(posedge clk); #1;
        chk("hold next accept", 128'(b0), 128'(1));
        wait_valid(1'b0, 8, "hold next");
        chk("hold next rdata", rd0, A5V);
        end_req(1'b0, "hold next");

        // Abort two cycles into a write
        start_req(1'b0, 1'b1, 16'h0012, ABV);
        repeat (3) begin @(posedge clk); #1; end
        valid0 = 1'b0;
        @(posedge clk); #1;
        chk("abort idle", 128'(b0), 128'(0));
        begin
            int seen;
            seen = 0;
            repeat (6) begin @(posedge clk); #1; if (v0) seen++; end
            chk("abort no response", 128'(seen), 128'(0));
        end
        do_txn(1'b0, 1'b0, 16'h0012, '0, 8, 1'b0, DEADV, "abort readback");

        // Abort on the completing edge itself
        start_req(1'b0, 1'b1, 16'h0012, ABV);
        repeat (4) begin @(posedge clk); #1; end
        valid0 = 1'b0;
        @(posedge clk); #1;
        chk("late abort valid", 128'(v0), 128'(0));
        chk("late abort idle", 128'(b0), 128'(0));
        do_txn(1'b0, 1'b0, 16'h0012, '0, 8, 1'b0, DEADV, "late abort readback");

        // Asynchronous reset in the middle of a write wait
        start_req(1'b0, 1'b1, 16'h0012, ABV);
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("rst wait busy", 128'(b0), 128'(0));
        chk("rst wait valid", 128'(v0), 128'(0));
        chk("rst wait err", 128'(e0), 128'(0));
        valid0 = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        do_txn(1'b0, 1'b0, 16'h0012, '0, 8, 1'b0, DEADV, "rst readback");

        // Asynchronous reset while an error response is held
        start_req(1'b1, 1'b0, 16'h00FF, '0);
        wait_resp(1'b1, 3, "rst resp");
        chk("rst resp err before", 128'(e1), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst resp valid", 128'(v1), 128'(0));
        chk("rst resp err", 128'(e1), 128'(0));
        chk("rst resp busy", 128'(b1), 128'(0));
        valid1 = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        do_txn(1'b1, 1'b0, 16'h0100, '0, 3, 1'b0, V1V, "rst resp readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
